// File: rtl/mpu_result_collector_pkg.sv
// Shared types for the MPU result collector: the float_sp element type, the drain states
// and a helper that sizes index fields.
package mpu_data_types;
    typedef logic [31:0] float_sp;

    typedef enum logic {
        COLLECTOR_IDLE  = 1'b0,
        COLLECTOR_WRITE = 1'b1
    } collector_state_e;

    // Width of an index into n entries, never less than one bit.
    function automatic int idx_bits(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction
endpackage

// File: rtl/mpu_result_collector_if.sv
// Collector bus: FMA results/readies in, register file write handshake out.
interface mpu_result_collector_if
    import mpu_data_types::*;
#(
    parameter int ROWS  = 6,
    parameter int COLS  = 6,
    parameter int RBITS = idx_bits(ROWS),
    parameter int CBITS = idx_bits(COLS)
);
    float_sp [ROWS*COLS-1:0] result_in;
    logic    [ROWS*COLS-1:0] ready_in;
    logic                    error_detected_in;
    logic                    reg_write_grant_in;
    logic                    collector_active_write_out;
    logic    [RBITS-1:0]     reg_collector_i_out;
    logic    [CBITS-1:0]     reg_collector_j_out;
    float_sp                 reg_collector_element_out;
    logic                    collector_finished;
    logic                    collector_overflow_out;

    modport master (
        output result_in, ready_in, error_detected_in, reg_write_grant_in,
        input  collector_active_write_out, reg_collector_i_out, reg_collector_j_out,
               reg_collector_element_out, collector_finished, collector_overflow_out
    );

    modport slave (
        input  result_in, ready_in, error_detected_in, reg_write_grant_in,
        output collector_active_write_out, reg_collector_i_out, reg_collector_j_out,
               reg_collector_element_out, collector_finished, collector_overflow_out
    );
endinterface

// File: rtl/mpu_collector_bank.sv
// One collector bank: element storage, arrival bitmap, all-ones detect and full flag.
module mpu_collector_bank
    import mpu_data_types::*;
#(
    parameter int N     = 36,
    parameter int KBITS = idx_bits(N)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             fill_en,
    input  logic             rel_en,
    input  logic [N-1:0]     ready,
    input  float_sp [N-1:0]  result,
    input  logic [KBITS-1:0] rd_idx,
    output logic             full,
    output logic             complete,
    output float_sp          rd_data
);
    float_sp      data [N];
    logic [N-1:0] bitmap;
    logic [N-1:0] bitmap_upd;
    logic         accept;

    // A full bank drops all readies, including in the cycle it is being released.
    assign accept     = fill_en && !full && !clr;
    assign bitmap_upd = bitmap | (accept ? ready : '0);
    assign complete   = accept && (&bitmap_upd);
    assign rd_data    = data[rd_idx];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bitmap <= '0;
            full   <= 1'b0;
        end else if (clr) begin
            bitmap <= '0;
            full   <= 1'b0;
        end else begin
            bitmap <= complete ? '0 : bitmap_upd;
            if (complete)    full <= 1'b1;
            else if (rel_en) full <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        for (int k = 0; k < N; k++)
            if (accept && ready[k]) data[k] <= result[k];
    end
endmodule

// File: rtl/mpu_result_collector.sv
// Double-buffered ROWSxCOLS result collector: one bank fills from the FMA cluster while the
// other drains to the register file one element per granted cycle.
module mpu_result_collector
    import mpu_data_types::*;
#(
    parameter int ROWS  = 6,
    parameter int COLS  = 6,
    parameter int RBITS = idx_bits(ROWS),
    parameter int CBITS = idx_bits(COLS)
) (
    input  logic clk,
    input  logic rst,
    mpu_result_collector_if.slave bus
);
    localparam int N     = ROWS * COLS;
    localparam int KBITS = idx_bits(N);

    collector_state_e state, state_n;
    logic             fill_sel, drain_sel;
    logic [1:0]       full, complete;
    float_sp          rd_data [2];
    logic [KBITS-1:0] k_q, k_n;
    logic [RBITS-1:0] i_q, i_n;
    logic [CBITS-1:0] j_q, j_n;
    logic             valid_q, valid_n, fin_q, fin_n, ovf_q, rel, load;
    float_sp          elem_q, elem_n;
    logic             err;

    assign err = bus.error_detected_in;

    for (genvar b = 0; b < 2; b++) begin : g_bank
        mpu_collector_bank #(.N(N), .KBITS(KBITS)) u_bank (
            .clk      (clk),
            .rst      (rst),
            .clr      (err),
            .fill_en  (fill_sel == 1'(b)),
            .rel_en   (rel && (drain_sel == 1'(b))),
            .ready    (bus.ready_in),
            .result   (bus.result_in),
            .rd_idx   (k_n),
            .full     (full[b]),
            .complete (complete[b]),
            .rd_data  (rd_data[b])
        );
    end

    always_comb begin
        state_n = state;
        k_n     = k_q;
        i_n     = i_q;
        j_n     = j_q;
        valid_n = valid_q;
        fin_n   = 1'b0;
        rel     = 1'b0;
        load    = 1'b0;
        case (state)
            COLLECTOR_IDLE: begin
                if (full[drain_sel]) begin
                    state_n = COLLECTOR_WRITE;
                    valid_n = 1'b1;
                    k_n     = '0;
                    i_n     = '0;
                    j_n     = '0;
                    load    = 1'b1;
                end
            end
            COLLECTOR_WRITE: begin
                if (bus.reg_write_grant_in) begin
                    if (k_q == KBITS'(N-1)) begin
                        rel     = 1'b1;
                        state_n = COLLECTOR_IDLE;
                        valid_n = 1'b0;
                        fin_n   = 1'b1;
                        k_n     = '0;
                        i_n     = '0;
                        j_n     = '0;
                    end else begin
                        k_n  = k_q + KBITS'(1);
                        load = 1'b1;
                        if (j_q == CBITS'(COLS-1)) begin
                            j_n = '0;
                            i_n = i_q + RBITS'(1);
                        end else begin
                            j_n = j_q + CBITS'(1);
                        end
                    end
                end
            end
            default: state_n = COLLECTOR_IDLE;
        endcase
        // Abort wins over any accept or bank start in the same cycle.
        if (err) begin
            state_n = COLLECTOR_IDLE;
            valid_n = 1'b0;
            fin_n   = 1'b0;
            rel     = 1'b0;
            load    = 1'b0;
            k_n     = '0;
            i_n     = '0;
            j_n     = '0;
        end
    end

    // The read port is addressed with the next index so the element register lines up with i/j.
    assign elem_n = load ? rd_data[drain_sel] : elem_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= COLLECTOR_IDLE;
            k_q       <= '0;
            i_q       <= '0;
            j_q       <= '0;
            valid_q   <= 1'b0;
            fin_q     <= 1'b0;
            elem_q    <= '0;
            fill_sel  <= 1'b0;
            drain_sel <= 1'b0;
            ovf_q     <= 1'b0;
        end else begin
            state   <= state_n;
            k_q     <= k_n;
            i_q     <= i_n;
            j_q     <= j_n;
            valid_q <= valid_n;
            fin_q   <= fin_n;
            elem_q  <= elem_n;
            if (err) begin
                fill_sel  <= 1'b0;
                drain_sel <= 1'b0;
            end else begin
                if (|complete) fill_sel  <= ~fill_sel;
                if (rel)       drain_sel <= ~drain_sel;
                ovf_q <= ovf_q | ((|bus.ready_in) && full[fill_sel]);
            end
        end
    end

    assign bus.collector_active_write_out = valid_q;
    assign bus.reg_collector_i_out        = i_q;
    assign bus.reg_collector_j_out        = j_q;
    assign bus.reg_collector_element_out  = elem_q;
    assign bus.collector_finished         = fin_q;
    assign bus.collector_overflow_out     = ovf_q;
endmodule
